// File: rtl/e203_irq_stim_gen.sv
`default_nettype none
// =============================================================================
// e203_irq_stim_gen: commit-PC driven random ext/sft/tmr interrupt generator
// Rev 1.0
// =============================================================================
module e203_irq_stim_gen #(
    parameter int unsigned        PC_SIZE    = 32,
    parameter logic [PC_SIZE-1:0] START_PC   = 32'h8000_015C,
    parameter logic [PC_SIZE-1:0] EXT_ACK_PC = 32'h8000_00A6,
    parameter logic [PC_SIZE-1:0] SFT_ACK_PC = 32'h8000_00BE,
    parameter logic [PC_SIZE-1:0] TMR_ACK_PC = 32'h8000_00D6,
    parameter logic [PC_SIZE-1:0] TOHOST_PC  = 32'h8000_0086,
    parameter logic [31:0]        STOP_CNT   = 32'd32,
    parameter int unsigned        DLY_W      = 10,
    parameter logic [31:0]        LFSR_SEED  = 32'h1ACE_B00C
) (
    input  logic               hfclk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cmt_valid,
    input  logic [PC_SIZE-1:0] cmt_pc,
    output logic               ext_irq,
    output logic               sft_irq,
    output logic               tmr_irq,
    output logic [31:0]        tohost_cnt,
    output logic [15:0]        ext_srv_cnt,
    output logic [15:0]        sft_srv_cnt,
    output logic [15:0]        tmr_srv_cnt,
    output logic               active,
    output logic               done
);

    localparam logic [31:0]  LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0]  SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [DLY_W:0] CNT_ONE = {{DLY_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RUN  = 2'd1,
        G_STOP = 2'd2
    } gstate_e;

    typedef enum logic [1:0] {
        C_OFF    = 2'd0,
        C_DLY    = 2'd1,
        C_ASSERT = 2'd2
    } cstate_e;

    gstate_e         g_state;
    gstate_e         g_state_nxt;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_nxt;
    logic            hit_start;
    logic            hit_tohost;
    logic [2:0]      hit_ack;
    logic            stop;
    logic            g_run;
    logic [2:0]      ch_off;
    logic            all_off;
    logic [2:0]      irq_vec;
    logic [2:0][15:0] srv_vec;

    assign hit_start  = cmt_valid && (cmt_pc == START_PC);
    assign hit_tohost = cmt_valid && (cmt_pc == TOHOST_PC);
    assign hit_ack    = {cmt_valid && (cmt_pc == TMR_ACK_PC),
                         cmt_valid && (cmt_pc == SFT_ACK_PC),
                         cmt_valid && (cmt_pc == EXT_ACK_PC)};
    assign stop       = (tohost_cnt > STOP_CNT);
    assign g_run      = (g_state == G_RUN);
    assign all_off    = &ch_off;

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_cnt <= 32'd0;
        end else if (hit_tohost && (tohost_cnt != 32'hFFFF_FFFF)) begin
            tohost_cnt <= tohost_cnt + 32'd1;
        end
    end

    // Galois LFSR advances only while stimulus is running
    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else if (g_run) begin
            lfsr <= lfsr_nxt;
        end
    end

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            g_state <= G_IDLE;
        end else begin
            g_state <= g_state_nxt;
        end
    end

    always_comb begin
        g_state_nxt = g_state;
        case (g_state)
            G_IDLE: if (en && hit_start) g_state_nxt = G_RUN;
            G_RUN: begin
                if (stop && all_off) begin
                    g_state_nxt = G_STOP;
                end else if (!en && all_off) begin
                    g_state_nxt = G_IDLE;
                end
            end
            G_STOP:  g_state_nxt = G_STOP;
            default: g_state_nxt = G_IDLE;
        endcase
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        cstate_e      ch_state;
        cstate_e      ch_state_nxt;
        logic [DLY_W:0] cnt;
        logic [DLY_W:0] cnt_nxt;
        logic [DLY_W:0] dly_load;
        logic         irq_q;
        logic         irq_nxt;
        logic [15:0]  srv;
        logic [15:0]  srv_nxt;
        logic         halt;

        // each channel draws its delay from a disjoint 10-bit lane of the LFSR
        assign dly_load = {1'b0, lfsr[i*10 +: DLY_W]} + CNT_ONE;
        assign halt     = !en || stop;

        always_comb begin
            ch_state_nxt = ch_state;
            cnt_nxt      = cnt;
            srv_nxt      = srv;
            case (ch_state)
                C_OFF: begin
                    if (g_run && !halt) begin
                        ch_state_nxt = C_DLY;
                        cnt_nxt      = dly_load;
                    end
                end
                C_DLY: begin
                    if (halt) begin
                        ch_state_nxt = C_OFF;
                        cnt_nxt      = '0;
                    end else if (cnt == CNT_ONE) begin
                        ch_state_nxt = C_ASSERT;
                        cnt_nxt      = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                C_ASSERT: begin
                    // only the handler-exit commit may release an asserted IRQ
                    if (hit_ack[i]) begin
                        srv_nxt = srv + 16'd1;
                        if (halt) begin
                            ch_state_nxt = C_OFF;
                        end else begin
                            ch_state_nxt = C_DLY;
                            cnt_nxt      = dly_load;
                        end
                    end
                end
                default: begin
                    ch_state_nxt = C_OFF;
                    cnt_nxt      = '0;
                end
            endcase
            irq_nxt = (ch_state_nxt == C_ASSERT);
        end

        always_ff @(posedge hfclk or negedge rst_n) begin
            if (!rst_n) begin
                ch_state <= C_OFF;
                cnt      <= '0;
                irq_q    <= 1'b0;
                srv      <= 16'd0;
            end else begin
                ch_state <= ch_state_nxt;
                cnt      <= cnt_nxt;
                irq_q    <= irq_nxt;
                srv      <= srv_nxt;
            end
        end

        assign irq_vec[i] = irq_q;
        assign srv_vec[i] = srv;
        assign ch_off[i]  = (ch_state == C_OFF);
    end

    assign ext_irq     = irq_vec[0];
    assign sft_irq     = irq_vec[1];
    assign tmr_irq     = irq_vec[2];
    assign ext_srv_cnt = srv_vec[0];
    assign sft_srv_cnt = srv_vec[1];
    assign tmr_srv_cnt = srv_vec[2];
    assign active      = (g_state == G_RUN);
    assign done        = (g_state == G_STOP);

endmodule
`default_nettype wire

// File: tb/tb_e203_irq_stim_gen.sv
`default_nettype none
// Directed bench for e203_irq_stim_gen with DLY_W=4, LFSR_SEED=5, STOP_CNT=2.
module tb_e203_irq_stim_gen;

    localparam logic [31:0] START_PC   = 32'h8000_015C;
    localparam logic [31:0] EXT_ACK_PC = 32'h8000_00A6;
    localparam logic [31:0] SFT_ACK_PC = 32'h8000_00BE;
    localparam logic [31:0] TMR_ACK_PC = 32'h8000_00D6;
    localparam logic [31:0] TOHOST_PC  = 32'h8000_0086;

    logic        hfclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cmt_valid;
    logic [31:0] cmt_pc;
    logic        ext_irq;
    logic        sft_irq;
    logic        tmr_irq;
    logic [31:0] tohost_cnt;
    logic [15:0] ext_srv_cnt;
    logic [15:0] sft_srv_cnt;
    logic [15:0] tmr_srv_cnt;
    logic        active;
    logic        done;

    int checks   = 0;
    int failures = 0;

    e203_irq_stim_gen #(
        .PC_SIZE   (32),
        .STOP_CNT  (32'd2),
        .DLY_W     (4),
        .LFSR_SEED (32'd5)
    ) dut (
        .hfclk       (hfclk),
        .rst_n       (rst_n),
        .en          (en),
        .cmt_valid   (cmt_valid),
        .cmt_pc      (cmt_pc),
        .ext_irq     (ext_irq),
        .sft_irq     (sft_irq),
        .tmr_irq     (tmr_irq),
        .tohost_cnt  (tohost_cnt),
        .ext_srv_cnt (ext_srv_cnt),
        .sft_srv_cnt (sft_srv_cnt),
        .tmr_srv_cnt (tmr_srv_cnt),
        .active      (active),
        .done        (done)
    );

    always #5 hfclk = ~hfclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; returns at the next negedge with the commit consumed.
    task automatic commit(input logic [31:0] pc);
        cmt_valid = 1'b1;
        cmt_pc    = pc;
        @(negedge hfclk);
        cmt_valid = 1'b0;
        cmt_pc    = 32'd0;
    endtask

    task automatic test_reset;
        logic [84:0] obs;
        rst_n = 1'b0; en = 1'b1; cmt_valid = 1'b0; cmt_pc = 32'd0;
        #12;
        obs = {ext_irq, sft_irq, tmr_irq, active, done, tohost_cnt, ext_srv_cnt, sft_srv_cnt, tmr_srv_cnt};
        checks++;
        if (obs !== 85'd0) begin
            failures++; $display("FAIL reset_outputs: got %0h want 0", obs);
        end
        @(negedge hfclk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge hfclk);
            obs = {ext_irq, sft_irq, tmr_irq, active, done, tohost_cnt, ext_srv_cnt, sft_srv_cnt, tmr_srv_cnt};
            checks++;
            if (obs !== 85'd0) begin
                failures++; $display("FAIL idle_outputs cyc%0d: got %0h want 0", k, obs);
            end
        end
    endtask

    task automatic test_arm;
        commit(START_PC);
        checks++;
        if (active !== 1'b1) begin
            failures++; $display("FAIL arm_active: got %b want 1", active);
        end
        // channels enter C_DLY at cycle 2; ext delay 6, sft/tmr delay 1
        for (int k = 2; k <= 8; k++) begin
            @(negedge hfclk);
            checks++;
            if (ext_irq !== (k == 8)) begin
                failures++; $display("FAIL arm_ext_rise c%0d: got %b want %b", k, ext_irq, (k == 8));
            end
            if (k == 2 || k == 3) begin
                checks++;
                if ({sft_irq, tmr_irq} !== ((k == 3) ? 2'b11 : 2'b00)) begin
                    failures++; $display("FAIL arm_sft_tmr c%0d: got %b want %b", k, {sft_irq, tmr_irq}, (k == 3) ? 2'b11 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_hold_ack;
        for (int k = 0; k < 50; k++) begin
            @(negedge hfclk);
            checks++;
            if ({ext_irq, sft_irq, tmr_irq} !== 3'b111) begin
                failures++; $display("FAIL hold_irqs cyc%0d: got %b want 111", k, {ext_irq, sft_irq, tmr_irq});
            end
        end
        commit(EXT_ACK_PC);
        checks++;
        if ({ext_irq, sft_irq, tmr_irq} !== 3'b011) begin
            failures++; $display("FAIL ack_ext_irqs: got %b want 011", {ext_irq, sft_irq, tmr_irq});
        end
        checks++;
        if ({ext_srv_cnt, sft_srv_cnt, tmr_srv_cnt} !== {16'd1, 16'd0, 16'd0}) begin
            failures++; $display("FAIL ack_ext_srv: got %0h/%0h/%0h want 1/0/0", ext_srv_cnt, sft_srv_cnt, tmr_srv_cnt);
        end
    endtask

    task automatic test_en_drop;
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge hfclk);
            checks++;
            if ({ext_irq, sft_irq, active} !== 3'b011) begin
                failures++; $display("FAIL endrop_hold cyc%0d: ext,sft,active got %b want 011", k, {ext_irq, sft_irq, active});
            end
        end
        commit(EXT_ACK_PC);
        checks++;
        if (ext_srv_cnt !== 16'd1) begin
            failures++; $display("FAIL endrop_stray_ack: ext_srv_cnt got %0d want 1", ext_srv_cnt);
        end
        commit(SFT_ACK_PC);
        checks++;
        if ({sft_irq, tmr_irq, active, sft_srv_cnt} !== {3'b011, 16'd1}) begin
            failures++; $display("FAIL endrop_sft_ack: sft,tmr,active got %b srv %0d want 011 srv 1", {sft_irq, tmr_irq, active}, sft_srv_cnt);
        end
        commit(TMR_ACK_PC);
        checks++;
        if ({tmr_irq, active, tmr_srv_cnt} !== {2'b01, 16'd1}) begin
            failures++; $display("FAIL endrop_tmr_ack: tmr,active got %b srv %0d want 01 srv 1", {tmr_irq, active}, tmr_srv_cnt);
        end
        @(negedge hfclk);
        checks++;
        if ({active, done, ext_irq} !== 3'b000) begin
            failures++; $display("FAIL endrop_idle: active,done,ext got %b want 000", {active, done, ext_irq});
        end
    endtask

    task automatic test_stop;
        int n = 0;
        int bad = 0;
        en = 1'b1;
        commit(START_PC);
        checks++;
        if (active !== 1'b1) begin
            failures++; $display("FAIL stop_rearm_active: got %b want 1", active);
        end
        while (tmr_irq !== 1'b1 && n < 64) begin
            @(negedge hfclk); n++;
        end
        checks++;
        if (tmr_irq !== 1'b1) begin
            failures++; $display("FAIL stop_wait_tmr: tmr_irq %b after %0d cycles want 1", tmr_irq, n);
        end
        for (int k = 0; k < 3; k++) begin
            commit(TOHOST_PC);
            checks++;
            if (tmr_irq !== 1'b1) begin
                failures++; $display("FAIL stop_tohost%0d_tmr: got %b want 1", k, tmr_irq);
            end
        end
        checks++;
        if (tohost_cnt !== 32'd3) begin
            failures++; $display("FAIL stop_tohost_cnt: got %0d want 3", tohost_cnt);
        end
        for (int k = 0; k < 23; k++) begin
            @(negedge hfclk);
            if (tmr_irq !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || done !== 1'b0) begin
            failures++; $display("FAIL stop_tmr_held: low cycles %0d done %b want 0 and 0", bad, done);
        end
        if (ext_irq === 1'b1) commit(EXT_ACK_PC);
        if (sft_irq === 1'b1) commit(SFT_ACK_PC);
        commit(TMR_ACK_PC);
        checks++;
        if (tmr_irq !== 1'b0) begin
            failures++; $display("FAIL stop_tmr_ack: got %b want 0", tmr_irq);
        end
        @(negedge hfclk);
        checks++;
        if ({done, active} !== 2'b10) begin
            failures++; $display("FAIL stop_done: done,active got %b want 10", {done, active});
        end
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge hfclk);
            if (ext_irq !== 1'b0 || sft_irq !== 1'b0 || tmr_irq !== 1'b0 || done !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stop_quiet: bad cycles %0d want 0", bad);
        end
    endtask

    task automatic test_async_reset;
        int n = 0;
        int bad = 0;
        logic [84:0] obs;
        rst_n = 1'b0;
        @(negedge hfclk);
        rst_n = 1'b1;
        commit(START_PC);
        @(negedge hfclk);
        @(negedge hfclk);
        checks++;
        if ({sft_irq, tmr_irq} !== 2'b11) begin
            failures++; $display("FAIL areset_pre_irqs: sft,tmr got %b want 11", {sft_irq, tmr_irq});
        end
        commit(SFT_ACK_PC);
        commit(TOHOST_PC);
        checks++;
        if ({tmr_irq, sft_srv_cnt, tohost_cnt} !== {1'b1, 16'd1, 32'd1}) begin
            failures++; $display("FAIL areset_pre_state: tmr %b sft_srv %0d tohost %0d want 1/1/1", tmr_irq, sft_srv_cnt, tohost_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {ext_irq, sft_irq, tmr_irq, active, done, tohost_cnt, ext_srv_cnt, sft_srv_cnt, tmr_srv_cnt};
        checks++;
        if (obs !== 85'd0) begin
            failures++; $display("FAIL areset_drop: got %0h want 0", obs);
        end
        @(negedge hfclk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge hfclk);
            if ({ext_irq, sft_irq, tmr_irq, active} !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL areset_no_rearm: bad cycles %0d want 0", bad);
        end
        commit(START_PC);
        checks++;
        if (active !== 1'b1) begin
            failures++; $display("FAIL areset_rearm: active got %b want 1", active);
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_hold_ack();
        test_en_drop();
        test_stop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
